// File: rtl/md_pkg.sv
// Shared types and constants for the md_div_sequencer iterative divider:
// operation codes, FSM states and the external ALU opcodes it issues.
package md_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NEG_A = 3'd1,
        NEG_B = 3'd2,
        CMP   = 3'd3,
        SUB   = 3'd4,
        FIX   = 3'd5,
        DONE  = 3'd6
    } state_e;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    // Two cycles (CMP + SUB) for each of the 32 quotient bits.
    localparam int ITER_CYCLES = 64;

endpackage

// File: rtl/md_div_sequencer.sv
// Restoring divider sequenced over a shared external ALU (DIV/DIVU/REM/REMU).
// Optional macro MD_DIV_ZERO_FAST_EN: divide-by-zero completes straight from IDLE.
module md_div_sequencer
    import md_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic        busy_o,
    input  logic        flush_i,
    output logic [3:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    input  logic [31:0] alu_data_i,
    output logic [2:0]  dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and response data is held
    // unchanged while resp_valid_o is high until resp_ready_i completes it.

    state_e      state_q, state_d;
    logic        armed_q, armed_d;
    op_e         op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] q_q, q_d;
    logic [31:0] bd_q, bd_d;
    logic [31:0] rem_q, rem_d;
    logic        r_msb_q, r_msb_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ge_q, ge_d;
    logic [31:0] res_q, res_d;

    logic [3:0]  seq_op;
    logic [31:0] seq_a;
    logic [31:0] seq_b;
    logic        is_signed;
    logic        is_rem;
    logic [31:0] fix_x;
    logic        fix_neg;

    assign is_signed = (op_q == DIV) || (op_q == REM);
    assign is_rem    = (op_q == REM) || (op_q == REMU);

    always_comb begin
        state_d = state_q;
        armed_d = 1'b1;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        bd_d    = bd_q;
        rem_d   = rem_q;
        r_msb_d = r_msb_q;
        cnt_d   = cnt_q;
        ge_d    = ge_q;
        res_d   = res_q;
        seq_op  = ALU_ADD;
        seq_a   = '0;
        seq_b   = '0;
        fix_x   = is_rem ? rem_q : q_q;
        fix_neg = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_o && !flush_i) begin
                    op_d    = op_e'(req_op_i);
                    a_d     = req_a_i;
                    b_d     = req_b_i;
                    rem_d   = '0;
                    r_msb_d = 1'b0;
                    cnt_d   = 5'd31;
                    ge_d    = 1'b0;
                    state_d = NEG_A;
`ifdef MD_DIV_ZERO_FAST_EN
                    if (req_b_i == 32'd0) begin
                        res_d   = req_op_i[1] ? req_a_i : 32'hFFFF_FFFF;
                        state_d = DONE;
                    end
`endif
                end
            end
            NEG_A: begin
                seq_op  = ALU_SUB;
                seq_b   = a_q;
                q_d     = (is_signed && a_q[31]) ? alu_data_i : a_q;
                state_d = NEG_B;
            end
            NEG_B: begin
                seq_op  = ALU_SUB;
                seq_b   = b_q;
                bd_d    = (is_signed && b_q[31]) ? alu_data_i : b_q;
                state_d = CMP;
            end
            CMP: begin
                // Compare the shifted remainder; its dropped MSB forces ge.
                seq_op  = ALU_SLTU;
                seq_a   = {rem_q[30:0], q_q[31]};
                seq_b   = bd_q;
                r_msb_d = rem_q[31];
                rem_d   = {rem_q[30:0], q_q[31]};
                ge_d    = rem_q[31] | ~alu_data_i[0];
                state_d = SUB;
            end
            SUB: begin
                seq_op = ALU_SUB;
                seq_a  = rem_q;
                seq_b  = bd_q;
                if (ge_q) begin
                    rem_d   = alu_data_i;
                    r_msb_d = 1'b0;
                end
                q_d = {q_q[30:0], ge_q};
                if (cnt_q == 5'd0) begin
                    state_d = FIX;
                end else begin
                    cnt_d   = cnt_q - 5'd1;
                    state_d = CMP;
                end
            end
            FIX: begin
                // A zero divisor keeps the all-ones quotient regardless of signs.
                seq_op  = ALU_SUB;
                seq_b   = fix_x;
                fix_neg = is_rem ? (is_signed && a_q[31])
                                 : (is_signed && (b_q != 32'd0) && (a_q[31] ^ b_q[31]));
                res_d   = fix_neg ? alu_data_i : fix_x;
                state_d = DONE;
            end
            DONE: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            op_q    <= DIV;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            bd_q    <= '0;
            rem_q   <= '0;
            r_msb_q <= 1'b0;
            cnt_q   <= '0;
            ge_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            bd_q    <= bd_d;
            rem_q   <= rem_d;
            r_msb_q <= r_msb_d;
            cnt_q   <= cnt_d;
            ge_q    <= ge_d;
            res_q   <= res_d;
        end
    end

    // armed_q keeps ready low until the first edge after reset release.
    assign req_ready_o  = (state_q == IDLE) && armed_q;
    assign busy_o       = (state_q != IDLE);
    assign resp_valid_o = (state_q == DONE);
    assign resp_data_o  = resp_valid_o ? res_q : '0;
    assign dbg_state_o  = state_q;

    assign alu_op_o = busy_o ? seq_op : ALU_ADD;
    assign alu_a_o  = busy_o ? seq_a  : '0;
    assign alu_b_o  = busy_o ? seq_b  : '0;

endmodule

// File: tb/tb_md_div_sequencer.sv
// Directed bench for md_div_sequencer with a behavioural model of the shared ALU.
// Honours MD_DIV_ZERO_FAST_EN for the divide-by-zero latency expectation.
module tb_md_div_sequencer;
    import md_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;
    logic        flush;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_data;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    localparam int LAT = 3 + ITER_CYCLES;
`ifdef MD_DIV_ZERO_FAST_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = LAT;
`endif

    md_div_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .busy_o       (busy),
        .flush_i      (flush),
        .alu_op_o     (alu_op),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_data_i   (alu_data),
        .dbg_state_o  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external ALU model
    always_comb begin
        alu_data = '0;
        case (alu_op)
            4'b0000: alu_data = alu_a + alu_b;
            4'b0001: alu_data = alu_a - alu_b;
            4'b0011: alu_data = {31'd0, (alu_a < alu_b)};
            default: alu_data = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (!req_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    // Called just after the accept edge; counts edges until resp_valid.
    task automatic finish_op(input string tag, input int exp_lat, input bit hold);
        int cyc = 0;
        logic [31:0] exp;
        while (!resp_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, " lat"}, cyc, exp_lat);
        check({tag, " data"}, resp_data, exp);
        check({tag, " done_alu"}, {alu_op, alu_a[27:0] | alu_b[27:0]}, 32'd0);
        if (!hold) tick();
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        exp_q.push_back(exp);
        wait_ready(tag);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        finish_op(tag, exp_lat, 1'b0);
    endtask

    initial begin : stim
        bit seen;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        flush      = 1'b0;

        #12;
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_alu_op", {28'd0, alu_op}, 32'd0);
        check("rst_alu_ab", alu_a | alu_b, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check("post_rst_state", {29'd0, dbg_state}, {29'd0, IDLE});

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, LAT);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, LAT);
        run_op("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, LAT);
        run_op("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, LAT);
        run_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, LAT);
        run_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, LAT);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT);
        run_op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, ZLAT);
        run_op("rem_5_0", 2'b10, 32'd5, 32'd0, 32'd5, ZLAT);
        run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, ZLAT);
        run_op("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, ZLAT);
        run_op("div_m7_m2", 2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, LAT);
        run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, LAT);

        // response backpressure, then accept the cycle after the handshake
        exp_q.push_back(32'd14);
        wait_ready("bp");
        req_op = 2'b01; req_a = 32'd100; req_b = 32'd7;
        req_valid = 1'b1; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        check("bp_busy", {31'd0, busy}, 32'd1);
        check("bp_ready_low", {31'd0, req_ready}, 32'd0);
        finish_op("bp", LAT, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_hold_data", resp_data, 32'd14);
            check("bp_hold_ready", {31'd0, req_ready}, 32'd0);
        end
        exp_q.push_back(32'd2);
        req_op = 2'b11; req_valid = 1'b1; resp_ready = 1'b1;
        tick();
        check("bp_handshake_idle", {31'd0, busy}, 32'd0);
        check("bp_handshake_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("bp_next_accept", {31'd0, busy}, 32'd1);
        finish_op("bp_next", LAT, 1'b0);

        // flush beats a simultaneous request in IDLE
        req_valid = 1'b1; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        check("flush_idle_no_accept", {31'd0, busy}, 32'd0);

        // flush mid-sequence
        wait_ready("fl");
        req_op = 2'b01; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (29) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_ready", {31'd0, req_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (resp_valid) seen = 1'b1;
        end
        check("flush_no_resp", {31'd0, seen}, 32'd0);

        // asynchronous reset mid-sequence
        wait_ready("rs");
        req_op = 2'b00; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (39) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        check("mid_rst_alu", {28'd0, alu_op} | alu_a | alu_b | resp_data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("mid_rst_rearm", {31'd0, req_ready}, 32'd1);
        run_op("after_rst", 2'b01, 32'd1000, 32'd10, 32'd100, LAT);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
